// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the alu datapath stage.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;

    localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/alu_addsub.sv
// Signed add/subtract with overflow detection; clamps on overflow when ALU_SATURATE_EN is defined.
module alu_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] full;

    assign a_ext = {a_i[WIDTH-1], a_i};
    assign b_ext = {b_i[WIDTH-1], b_i};
    assign full  = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

    // The WIDTH+1 result is exact, so its top two bits disagree only when it does not fit.
    assign ovf_o = full[WIDTH] ^ full[WIDTH-1];

`ifdef ALU_SATURATE_EN
    always_comb begin
        sum_o = full[WIDTH-1:0];
        if (ovf_o) begin
            sum_o = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_o = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/alu.sv
// Registered signed ALU (ADD/SUB/AND/OR) with Z/N/V flags; ALU_SATURATE_EN selects clamping add/sub.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic [WIDTH-1:0]  i_arg0,
    input  logic [WIDTH-1:0]  i_arg1,
    input  logic [1:0]        i_oper,
    output logic [WIDTH-1:0]  o_result,
    output logic [FLAG_W-1:0] o_flag
);

    logic [WIDTH-1:0]  as_sum;
    logic              as_ovf;
    logic              sub_sel;
    logic [WIDTH-1:0]  result_d, result_q;
    logic [FLAG_W-1:0] flag_d, flag_q;
    logic              ovf_d;

    assign sub_sel = (i_oper == OP_SUB);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i  (i_arg0),
        .b_i  (i_arg1),
        .sub_i(sub_sel),
        .sum_o(as_sum),
        .ovf_o(as_ovf)
    );

    always_comb begin
        result_d = as_sum;
        ovf_d    = 1'b0;
        unique case (i_oper)
            OP_ADD, OP_SUB: begin
                result_d = as_sum;
                ovf_d    = as_ovf;
            end
            OP_AND: result_d = i_arg0 & i_arg1;
            OP_OR:  result_d = i_arg0 | i_arg1;
            default: begin
                result_d = as_sum;
                ovf_d    = 1'b0;
            end
        endcase

        flag_d         = '0;
        flag_d[FLAG_Z] = (result_d == '0);
        flag_d[FLAG_N] = result_d[WIDTH-1];
        flag_d[FLAG_V] = ovf_d;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign o_result = result_q;
    assign o_flag   = flag_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected results, monitor checks one cycle later.
module tb_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] arg0;
    logic [W-1:0] arg1;
    logic [1:0]   oper;
    logic [W-1:0] result;
    logic [2:0]   flag;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_res_q[$];
    logic [2:0]   exp_flag_q[$];

    alu #(
        .WIDTH(W)
    ) dut (
        .i_CLK   (clk),
        .i_RSTn  (rst_n),
        .i_arg0  (arg0),
        .i_arg1  (arg1),
        .i_oper  (oper),
        .o_result(result),
        .o_flag  (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then wrap or clamp to the signed range.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] op, output logic [W-1:0] res,
                                  output logic [2:0] fl);
        int sa, sb, s, lo, hi;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        lo = -(1 << (W - 1));
        hi = (1 << (W - 1)) - 1;
        v  = 1'b0;
        case (op)
            2'd0, 2'd1: begin
                s = (op == 2'd0) ? sa + sb : sa - sb;
                v = (s > hi) || (s < lo);
`ifdef ALU_SATURATE_EN
                if (s > hi) s = hi;
                if (s < lo) s = lo;
`endif
                res = s[W-1:0];
            end
            2'd2:    res = a & b;
            default: res = a | b;
        endcase
        fl = {v, res[W-1], (res == '0)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] r, input logic [2:0] f,
                         input logic [W-1:0] er, input logic [2:0] ef);
        total++;
        if (r !== er || f !== ef) begin
            bad++;
            $display("FAIL %s: got result=%h flag=%b, want result=%h flag=%b",
                     name, r, f, er, ef);
        end
    endtask

    // Monitor: every cycle an expected entry is pending, compare it just after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_res_q.size() > 0) begin
            check("scoreboard", result, flag, exp_res_q.pop_front(), exp_flag_q.pop_front());
        end
    end

    task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                             input logic [W-1:0] er, input logic [2:0] ef);
        @(negedge clk);
        arg0 = a;
        arg1 = b;
        oper = op;
        exp_res_q.push_back(er);
        exp_flag_q.push_back(ef);
    endtask

    task automatic issue_model(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op);
        logic [W-1:0] er;
        logic [2:0]   ef;
        model(a, b, op, er, ef);
        issue_exp(a, b, op, er, ef);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        arg0  = 8'h55;
        arg1  = 8'h22;
        oper  = 2'b00;
        #1;
        check("reset_init", result, flag, 8'h00, 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold_init", result, flag, 8'h00, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        issue_exp(8'd5, 8'hFB, 2'b00, 8'h00, 3'b001);
        issue_exp(8'hF0, 8'h0F, 2'b10, 8'h00, 3'b001);
        issue_exp(8'h80, 8'h01, 2'b11, 8'h81, 3'b010);
        issue_exp(8'd10, 8'd3, 2'b00, 8'd13, 3'b000);
        issue_exp(8'd10, 8'd3, 2'b01, 8'd7, 3'b000);
`ifdef ALU_SATURATE_EN
        issue_exp(8'h80, 8'h01, 2'b01, 8'h80, 3'b110);
        issue_exp(8'd100, 8'd50, 2'b00, 8'h7F, 3'b100);
`else
        issue_exp(8'h80, 8'h01, 2'b01, 8'h7F, 3'b100);
        issue_exp(8'd100, 8'd50, 2'b00, 8'h96, 3'b110);
`endif

        // Mid-stream asynchronous reset while the output is nonzero.
        @(negedge clk);
        arg0 = 8'd20;
        arg1 = 8'd30;
        rst_n = 1'b0;
        #1;
        check("reset_async", result, flag, 8'h00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            arg0 = 8'($urandom);
            arg1 = 8'($urandom);
            check("reset_held", result, flag, 8'h00, 3'b000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        issue_model(8'd1, 8'd2, 2'b00);
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 20; i++) begin
                issue_model(8'($urandom), 8'($urandom), 2'(op));
            end
        end
        for (int i = 0; i < 40; i++) begin
            issue_model(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        end

        guard = 0;
        while (exp_res_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        total++;
        if (exp_res_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_res_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
